// File: rtl/axi_lite_host_initiator.sv
// ---------------------------------------------------------------------------
// axi_lite_host_initiator
//
// Turns a simple command/response handshake into single-beat AXI4 read and
// write transactions. It is used by the test harness to drive the cluster's
// narrow slave port, so the bench can preload memory, poke peripherals and
// read back results. Only one transaction is ever in flight.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake (ready only while idle)
//   cmd_write_i              1 = write, 0 = read
//   cmd_addr_i               byte address, forwarded unmodified
//   cmd_wdata_i/cmd_strb_i   write data and byte strobes
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_rdata_o              read data (0 for writes)
//   rsp_resp_o               BRESP / RRESP of the completed transaction
//   protocol_err_o           sticky: B/R with a foreign ID, or R with last=0
//   axi_req_o / axi_rsp_i    AXI4 request / response structs
// ---------------------------------------------------------------------------
package axi_lite_host_initiator_pkg;
    typedef struct packed {
        logic [5:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [0:0]  user;
    } w_chan_t;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } ar_chan_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } axi_rsp_t;
endpackage

module axi_lite_host_initiator #(
    parameter int unsigned AxiAddrWidth = 48,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 6,
    parameter int unsigned AxiUserWidth = 1,
    parameter int unsigned AxiId        = 0,
    parameter type req_t = axi_lite_host_initiator_pkg::axi_req_t,
    parameter type rsp_t = axi_lite_host_initiator_pkg::axi_rsp_t
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [AxiAddrWidth-1:0]   cmd_addr_i,
    input  logic [AxiDataWidth-1:0]   cmd_wdata_i,
    input  logic [AxiDataWidth/8-1:0] cmd_strb_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [AxiDataWidth-1:0]   rsp_rdata_o,
    output logic [1:0]                rsp_resp_o,
    output logic                      protocol_err_o,
    output req_t                      axi_req_o,
    input  rsp_t                      axi_rsp_i
);
    localparam int unsigned StrbWidth = AxiDataWidth / 8;
    localparam logic [2:0]  AxSize    = 3'($clog2(StrbWidth));
    localparam logic [1:0]  BurstIncr = 2'b01;
    localparam logic [AxiIdWidth-1:0] OwnId = AxiIdWidth'(AxiId);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_B,
        READ_AR,
        WAIT_R,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    req_t                    axi_req_q, axi_req_d;
    logic [AxiDataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic                    protocol_err_q, protocol_err_d;

    logic cmd_hs;
    logic aw_hs;
    logic w_hs;

    assign cmd_ready_o = (state_q == IDLE);
    assign cmd_hs      = cmd_valid_i && cmd_ready_o;
    assign aw_hs       = axi_req_q.aw_valid && axi_rsp_i.aw_ready;
    assign w_hs        = axi_req_q.w_valid && axi_rsp_i.w_ready;

    always_comb begin
        state_d        = state_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        axi_req_d      = axi_req_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_resp_d     = rsp_resp_q;
        protocol_err_d = protocol_err_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    // Payload is captured once here and held untouched until
                    // the next accept, which keeps it stable while valid.
                    axi_req_d.aw.id    = OwnId;
                    axi_req_d.aw.addr  = cmd_addr_i;
                    axi_req_d.aw.len   = '0;
                    axi_req_d.aw.size  = AxSize;
                    axi_req_d.aw.burst = BurstIncr;
                    axi_req_d.aw.user  = AxiUserWidth'(0);
                    axi_req_d.ar.id    = OwnId;
                    axi_req_d.ar.addr  = cmd_addr_i;
                    axi_req_d.ar.len   = '0;
                    axi_req_d.ar.size  = AxSize;
                    axi_req_d.ar.burst = BurstIncr;
                    axi_req_d.ar.user  = AxiUserWidth'(0);
                    axi_req_d.w.data   = cmd_wdata_i;
                    axi_req_d.w.strb   = cmd_strb_i;
                    axi_req_d.w.last   = 1'b1;
                    axi_req_d.w.user   = AxiUserWidth'(0);
                    aw_done_d          = 1'b0;
                    w_done_d           = 1'b0;
                    state_d            = cmd_write_i ? WRITE : READ_AR;
                end
            end
            WRITE: begin
                // AW and W complete independently, in either order.
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WAIT_B;
                end
            end
            WAIT_B: begin
                if (axi_rsp_i.b_valid) begin
                    rsp_resp_d  = axi_rsp_i.b.resp;
                    rsp_rdata_d = '0;
                    if (axi_rsp_i.b.id != OwnId) begin
                        protocol_err_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            READ_AR: begin
                // ar_valid is registered high for the whole of READ_AR.
                if (axi_rsp_i.ar_ready) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                if (axi_rsp_i.r_valid) begin
                    rsp_rdata_d = axi_rsp_i.r.data;
                    rsp_resp_d  = axi_rsp_i.r.resp;
                    if ((axi_rsp_i.r.id != OwnId) || !axi_rsp_i.r.last) begin
                        protocol_err_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake signals are registered from the next state so they come
        // straight off flops and drop to zero on reset.
        axi_req_d.aw_valid = (state_d == WRITE) && !aw_done_d;
        axi_req_d.w_valid  = (state_d == WRITE) && !w_done_d;
        axi_req_d.ar_valid = (state_d == READ_AR);
        axi_req_d.b_ready  = (state_d == WAIT_B);
        axi_req_d.r_ready  = (state_d == WAIT_R);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            axi_req_q      <= '0;
            rsp_rdata_q    <= '0;
            rsp_resp_q     <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            aw_done_q      <= aw_done_d;
            w_done_q       <= w_done_d;
            axi_req_q      <= axi_req_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_resp_q     <= rsp_resp_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign axi_req_o      = axi_req_q;
    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_resp_o     = rsp_resp_q;
    assign protocol_err_o = protocol_err_q;

    // User fields of the responses carry nothing this initiator acts on.
    logic unused_rsp_user;
    assign unused_rsp_user = ^{axi_rsp_i.b.user, axi_rsp_i.r.user};

endmodule

// File: tb/tb_axi_lite_host_initiator.sv
module tb_axi_lite_host_initiator;
    import axi_lite_host_initiator_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [47:0] cmd_addr_i;
    logic [63:0] cmd_wdata_i;
    logic [7:0]  cmd_strb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic [1:0]  rsp_resp_o;
    logic        protocol_err_o;
    axi_req_t    axi_req;
    axi_rsp_t    axi_rsp;

    axi_lite_host_initiator dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_write_i    (cmd_write_i),
        .cmd_addr_i     (cmd_addr_i),
        .cmd_wdata_i    (cmd_wdata_i),
        .cmd_strb_i     (cmd_strb_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_resp_o     (rsp_resp_o),
        .protocol_err_o (protocol_err_o),
        .axi_req_o      (axi_req),
        .axi_rsp_i      (axi_rsp)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  resp;
        int          lat;   // -1: latency not checked
        int          acc;   // cycle of command accept
        string       name;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   rsp_hs = 0;

    initial forever begin
        @(negedge clk_i);
        if (rst_ni && rsp_valid_o && rsp_ready_i) begin
            rsp_hs++;
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_rdata"}, rsp_rdata_o, mon_e.rdata);
                chk({mon_e.name, "_resp"}, {62'd0, rsp_resp_o}, {62'd0, mon_e.resp});
                if (mon_e.lat >= 0) begin
                    chk({mon_e.name, "_latency"}, 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                end
            end
        end
    end

    // ---------------- slave model ----------------
    logic [63:0] mem [logic [47:0]];
    int          aw_delay = 0;
    int          aw_cnt = 0, aw_hi = 0, w_hi = 0, b_hs = 0;
    logic [1:0]  bresp_cfg = 2'd0, rresp_cfg = 2'd0;
    logic [5:0]  rid_cfg = 6'd0;
    logic        stall_b = 1'b0;
    logic        got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0;
    aw_chan_t    aw_seen;
    w_chan_t     w_seen;
    ar_chan_t    ar_seen;

    function automatic logic [63:0] rd_mem(input logic [47:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    initial begin
        axi_rsp = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                axi_rsp = '0;
                got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; aw_cnt = 0;
                continue;
            end
            // B and R first, so a response appears the negedge after the
            // address/data handshake was granted.
            axi_rsp.b_valid = 1'b0;
            axi_rsp.b = '0;
            if (b_pend && !stall_b) begin
                axi_rsp.b_valid = 1'b1;
                axi_rsp.b.id    = 6'd0;
                axi_rsp.b.resp  = bresp_cfg;
                if (axi_req.b_ready) begin
                    b_pend = 0;
                    b_hs++;
                end
            end
            axi_rsp.r_valid = 1'b0;
            axi_rsp.r = '0;
            if (r_pend) begin
                axi_rsp.r_valid = 1'b1;
                axi_rsp.r.id    = rid_cfg;
                axi_rsp.r.data  = rd_mem(ar_seen.addr);
                axi_rsp.r.resp  = rresp_cfg;
                axi_rsp.r.last  = 1'b1;
                if (axi_req.r_ready) r_pend = 0;
            end
            axi_rsp.aw_ready = 1'b0;
            if (axi_req.aw_valid) begin
                aw_hi++;
                if (aw_cnt >= aw_delay) begin
                    axi_rsp.aw_ready = 1'b1;
                    aw_cnt  = 0;
                    got_aw  = 1;
                    aw_seen = axi_req.aw;
                end else begin
                    aw_cnt++;
                end
            end
            axi_rsp.w_ready = 1'b0;
            if (axi_req.w_valid) begin
                w_hi++;
                axi_rsp.w_ready = 1'b1;
                got_w  = 1;
                w_seen = axi_req.w;
            end
            if (got_aw && got_w) begin
                logic [63:0] word;
                word = rd_mem(aw_seen.addr);
                for (int i = 0; i < 8; i++) begin
                    if (w_seen.strb[i]) word[8*i +: 8] = w_seen.data[8*i +: 8];
                end
                mem[aw_seen.addr] = word;
                b_pend = 1;
                got_aw = 0;
                got_w  = 0;
            end
            axi_rsp.ar_ready = 1'b0;
            if (axi_req.ar_valid) begin
                axi_rsp.ar_ready = 1'b1;
                ar_seen = axi_req.ar;
                r_pend  = 1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input string name, input logic wr, input logic [47:0] addr,
                         input logic [63:0] wdata, input logic [7:0] strb,
                         input logic [63:0] exp_rdata, input logic [1:0] exp_resp,
                         input int lat);
        exp_t e;
        int   n;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_strb_i  = strb;
        n = 0;
        @(negedge clk_i);
        while (!cmd_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!cmd_ready_o) chk({name, "_cmd_accept"}, 64'd0, 64'd1);
        e.rdata = exp_rdata;
        e.resp  = exp_resp;
        e.lat   = lat;
        e.acc   = cyc;
        e.name  = name;
        sb.push_back(e);
        @(posedge clk_i); #1;
        // The DUT owns its copy now; scramble the inputs.
        cmd_valid_i = 1'b0;
        cmd_write_i = ~wr;
        cmd_addr_i  = 48'hFFFF_FFFF_FFFF;
        cmd_wdata_i = 64'h5A5A_5A5A_5A5A_5A5A;
        cmd_strb_i  = 8'h00;
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk({name, "_done"}, 64'(sb.size()), 64'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_ni      = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        cmd_strb_i  = '0;
        rsp_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_axi_req_zero", 64'(axi_req == '0), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_rdata", rsp_rdata_o, 64'd0);
        chk("rst_resp", 64'(rsp_resp_o), 64'd0);
        chk("rst_err", 64'(protocol_err_o), 64'd0);
        #2 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);

        // T1: zero-wait write
        issue("t1_wr", 1'b1, 48'h0000_1000_0000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'h0, 2'd0, 3);
        @(negedge clk_i);
        chk("t1_aw_valid", 64'(axi_req.aw_valid), 64'd1);
        chk("t1_w_valid", 64'(axi_req.w_valid), 64'd1);
        chk("t1_aw_addr", 64'(axi_req.aw.addr), 64'h1000_0000);
        chk("t1_aw_size", 64'(axi_req.aw.size), 64'd3);
        chk("t1_aw_len", 64'(axi_req.aw.len), 64'd0);
        chk("t1_aw_burst", 64'(axi_req.aw.burst), 64'd1);
        chk("t1_aw_id", 64'(axi_req.aw.id), 64'd0);
        chk("t1_w_last", 64'(axi_req.w.last), 64'd1);
        chk("t1_w_data", axi_req.w.data, 64'hDEAD_BEEF_CAFE_F00D);
        chk("t1_w_strb", 64'(axi_req.w.strb), 64'hFF);
        wait_rsp("t1_wr");

        // T2: read back
        issue("t2_rd", 1'b0, 48'h0000_1000_0000, 64'h0, 8'h0, 64'hDEAD_BEEF_CAFE_F00D, 2'd0, 3);
        @(negedge clk_i);
        chk("t2_ar_valid", 64'(axi_req.ar_valid), 64'd1);
        chk("t2_ar_addr", 64'(axi_req.ar.addr), 64'h1000_0000);
        chk("t2_ar_size", 64'(axi_req.ar.size), 64'd3);
        wait_rsp("t2_rd");

        // T3: aw_ready delayed, w_ready immediate, partial strobe
        aw_delay = 4; aw_hi = 0; w_hi = 0; b_hs = 0; rsp_hs = 0;
        issue("t3_wr", 1'b1, 48'h0000_0000_2000, 64'h1122_3344_5566_7788, 8'h0F, 64'h0, 2'd0, -1);
        wait_rsp("t3_wr");
        chk("t3_aw_valid_cycles", 64'(aw_hi), 64'd5);
        chk("t3_w_valid_cycles", 64'(w_hi), 64'd1);
        chk("t3_b_count", 64'(b_hs), 64'd1);
        chk("t3_rsp_count", 64'(rsp_hs), 64'd1);
        aw_delay = 0;
        issue("t3_rd", 1'b0, 48'h0000_0000_2000, 64'h0, 8'h0, 64'h0000_0000_5566_7788, 2'd0, 3);
        wait_rsp("t3_rd");

        // T4: SLVERR on read
        rresp_cfg = 2'd2;
        issue("t4_rd", 1'b0, 48'h0000_0000_2000, 64'h0, 8'h0, 64'h0000_0000_5566_7788, 2'd2, 3);
        wait_rsp("t4_rd");
        chk("t4_err", 64'(protocol_err_o), 64'd0);
        rresp_cfg = 2'd0;

        // T5: foreign read ID sets sticky error
        rid_cfg = 6'd5;
        issue("t5_rd", 1'b0, 48'h0000_1000_0000, 64'h0, 8'h0, 64'hDEAD_BEEF_CAFE_F00D, 2'd0, 3);
        wait_rsp("t5_rd");
        chk("t5_err_set", 64'(protocol_err_o), 64'd1);
        rid_cfg = 6'd0;
        issue("t5_wr", 1'b1, 48'h0000_0000_3000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 2'd0, 3);
        wait_rsp("t5_wr");
        chk("t5_err_sticky", 64'(protocol_err_o), 64'd1);

        // T6: response back-pressure
        rsp_ready_i = 1'b0;
        issue("t6_rd", 1'b0, 48'h0000_0000_3000, 64'h0, 8'h0, 64'h0123_4567_89AB_CDEF, 2'd0, -1);
        n = 0;
        while (!rsp_valid_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("t6_rsp_seen", 64'(rsp_valid_o), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("t6_hold_valid", 64'(rsp_valid_o), 64'd1);
            chk("t6_hold_rdata", rsp_rdata_o, 64'h0123_4567_89AB_CDEF);
            chk("t6_hold_cmd_ready", 64'(cmd_ready_o), 64'd0);
            if (i != 9) @(negedge clk_i);
        end
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("t6_cmd_ready_after", 64'(cmd_ready_o), 64'd1);
        chk("t6_sb_drained", 64'(sb.size()), 64'd0);

        // T7: reset while waiting for B
        stall_b = 1'b1;
        issue("t7_wr", 1'b1, 48'h0000_0000_4000, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 64'h0, 2'd0, -1);
        n = 0;
        while (!axi_req.b_ready && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("t7_in_wait_b", 64'(axi_req.b_ready), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t7_async_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                                    axi_req.b_ready, axi_req.r_ready, rsp_valid_o}), 64'd0);
        chk("t7_async_req_zero", 64'(axi_req == '0), 64'd1);
        chk("t7_err_cleared", 64'(protocol_err_o), 64'd0);
        sb.delete();
        stall_b = 1'b0;
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("t7_cmd_ready_after", 64'(cmd_ready_o), 64'd1);
        issue("t7_rd", 1'b0, 48'h0000_1000_0000, 64'h0, 8'h0, 64'hDEAD_BEEF_CAFE_F00D, 2'd0, 3);
        wait_rsp("t7_rd");
        chk("t7_err_clean", 64'(protocol_err_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
